// File: rtl/pulse_indicator_driver_pkg.sv
// ---------------------------------------------------------------------------
// pulse_indicator_driver_pkg
// Shared types and elaboration-time helpers for the pulse indicator driver:
//   - state_e        : blink sequencer states (IDLE, ON, OFF)
//   - ms_to_cycles() : converts a millisecond duration into clock cycles
//   - width_for()    : bit width needed to hold values 0..max_val (min 1)
// ---------------------------------------------------------------------------
package pulse_indicator_driver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  // Cycles per millisecond first, so large clock rates do not overflow
  // before the multiply.
  function automatic longint ms_to_cycles(input longint freq, input longint ms);
    return (freq / 1000) * ms;
  endfunction

  function automatic int width_for(input longint max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pulse_indicator_driver_blink_timer.sv
// ---------------------------------------------------------------------------
// pulse_indicator_driver_blink_timer
// Loadable down-counter shared by the ON and OFF phases. A load takes
// priority; otherwise the count decrements until it reaches zero and then
// rests there.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (count -> 0)
//   load       in   load load_value this cycle
//   load_value in   value to load (phase length minus one)
//   zero       out  count is zero (last cycle of the current phase)
// ---------------------------------------------------------------------------
module pulse_indicator_driver_blink_timer #(
  parameter int TW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  output logic          zero
);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (load) begin
      timer_d = load_value;
    end else if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign zero = (timer_q == '0);

endmodule

// File: rtl/pulse_indicator_driver.sv
// ---------------------------------------------------------------------------
// pulse_indicator_driver
// Turns debounced event pulses into visible LED blinks: one ON_MS blink per
// event followed by an OFF_MS dark gap. Events arriving while a blink is in
// progress are queued in a saturating counter; an event that finds the
// counter full is dropped and latches the sticky overflow flag.
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   event_in       in   event request, only its rising edge counts
//   clear_overflow in   synchronous clear of overflow (a same-cycle drop wins)
//   led_out        out  registered LED drive, 1 = lit
//   busy           out  registered, 1 while blinking or in the dark gap
//   pending        out  registered count of queued, not yet started events
//   overflow       out  sticky flag, an event was dropped at saturation
// ---------------------------------------------------------------------------
module pulse_indicator_driver
  import pulse_indicator_driver_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int ON_MS        = 100,
  parameter int OFF_MS       = 100,
  parameter int PENDING_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    event_in,
  input  logic                    clear_overflow,
  output logic                    led_out,
  output logic                    busy,
  output logic [PENDING_BITS-1:0] pending,
  output logic                    overflow
);

  localparam longint ON_CYC  = ms_to_cycles(longint'(CLK_FREQ), longint'(ON_MS));
  localparam longint OFF_CYC = ms_to_cycles(longint'(CLK_FREQ), longint'(OFF_MS));
  localparam longint MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int     TW      = width_for(MAX_CYC);

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYC - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYC - 1);
  localparam logic [PENDING_BITS-1:0] PEND_MAX = '1;

  if (ON_CYC < 1) begin : g_on_cyc_check
    $error("pulse_indicator_driver: ON phase shorter than one clock cycle");
  end
  if (OFF_CYC < 1) begin : g_off_cyc_check
    $error("pulse_indicator_driver: OFF phase shorter than one clock cycle");
  end

  state_e                  state_q, state_d;
  logic                    ev_dly_q;
  logic [PENDING_BITS-1:0] pend_q, pend_d;
  logic                    ovf_q, ovf_d;
  logic                    led_q, led_d;
  logic                    busy_q, busy_d;

  logic                    rise;
  logic                    start;
  logic                    drop;
  logic                    tmr_load;
  logic [TW-1:0]           tmr_value;
  logic                    tmr_zero;

  // ev_dly_q resets to 1 so an input already high at reset release is not
  // mistaken for a fresh event.
  assign rise = event_in & ~ev_dly_q;

  pulse_indicator_driver_blink_timer #(
    .TW (TW)
  ) u_blink_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  // Sequencer: a queued blink starts straight from the last OFF cycle, so
  // back-to-back blinks never pass through IDLE.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = ON_LOAD;
    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_d  = ON;
          start    = 1'b1;
          tmr_load = 1'b1;
        end
      end
      ON: begin
        if (tmr_zero) begin
          state_d   = OFF;
          tmr_load  = 1'b1;
          tmr_value = OFF_LOAD;
        end
      end
      OFF: begin
        if (tmr_zero) begin
          if (pend_q != '0) begin
            state_d  = ON;
            start    = 1'b1;
            tmr_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  // Queue: a rise and a start in the same cycle cancel out. A start only
  // happens with pend_q != 0, so the decrement cannot underflow.
  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;
    if (rise && !start) begin
      if (pend_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + PENDING_BITS'(1);
      end
    end else if (!rise && start) begin
      pend_d = pend_q - PENDING_BITS'(1);
    end
    ovf_d = clear_overflow ? 1'b0 : ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ev_dly_q <= 1'b1;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ev_dly_q <= event_in;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule
